// File: rtl/wb2sdrc_burst.sv
// Wishbone-to-SDRAM-controller bridge. Collects incrementing Wishbone writes into
// burst commands through a write FIFO and serves burst reads through a read FIFO.
module wb2sdrc_burst #(
  parameter int unsigned DW        = 32,
  parameter int unsigned APP_AW    = 26,
  parameter int unsigned BL        = 9,
  parameter int unsigned MAX_BURST = 8,
  parameter int unsigned WFD       = 16,
  parameter int unsigned RFD       = 16
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_i,
  input  logic                wb_stb_i,
  input  logic                wb_cyc_i,
  input  logic                wb_we_i,
  input  logic [2:0]          wb_cti_i,
  input  logic [APP_AW-1:0]   wb_addr_i,
  input  logic [DW-1:0]       wb_dat_i,
  input  logic [DW/8-1:0]     wb_sel_i,
  output logic [DW-1:0]       wb_dat_o,
  output logic                wb_ack_o,
  output logic                sdr_req,
  output logic [APP_AW-1:0]   sdr_req_addr,
  output logic [BL-1:0]       sdr_req_len,
  output logic                sdr_req_wr_n,
  input  logic                sdr_req_ack,
  input  logic                sdr_wr_next,
  output logic [DW-1:0]       sdr_wr_data,
  output logic [DW/8-1:0]     sdr_wr_en_n,
  input  logic                sdr_rd_valid,
  input  logic [DW-1:0]       sdr_rd_data,
  output logic                rd_ovf_o
);

  localparam int unsigned SW  = DW / 8;
  localparam int unsigned WFW = DW + SW;
  localparam int unsigned WAW = $clog2(WFD);
  localparam int unsigned WPW = WAW + 1;
  localparam int unsigned RAW = $clog2(RFD);
  localparam int unsigned RPW = RAW + 1;
  localparam int unsigned MBW = $clog2(MAX_BURST);

  typedef enum logic [2:0] {
    IDLE, WR_COLLECT, WR_ISSUE, RD_ISSUE, RD_DATA, RD_DRAIN
  } state_t;

  state_t              state, state_n;
  logic [APP_AW-1:0]   start_addr, start_addr_n;
  logic [BL-1:0]       beat_cnt, beat_cnt_n;
  logic [BL-1:0]       len_q, len_n;
  logic [BL-1:0]       ack_cnt, ack_cnt_n;
  logic [BL-1:0]       rcv_cnt;
  logic [BL-1:0]       beat_inc;
  logic [APP_AW-1:0]   next_addr;
  logic                wr_req, rd_req, incr;
  logic                wf_push, wf_pop, wf_empty, wf_full;
  logic                rf_push, rf_pop, rf_empty, rf_full;

  // Write FIFO: {active-low byte enables, data}, first-word fall-through
  logic [WFW-1:0] wf_mem [WFD];
  logic [WPW-1:0] wf_wptr, wf_rptr;
  logic [WFW-1:0] wf_head;

  assign wf_empty = (wf_wptr == wf_rptr);
  assign wf_full  = (wf_wptr[WAW] != wf_rptr[WAW]) &&
                    (wf_wptr[WAW-1:0] == wf_rptr[WAW-1:0]);
  assign wf_pop   = sdr_wr_next && !wf_empty;
  assign wf_head  = wf_mem[wf_rptr[WAW-1:0]];

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      wf_wptr <= '0;
      wf_rptr <= '0;
    end else begin
      if (wf_push) wf_wptr <= wf_wptr + WPW'(1);
      if (wf_pop)  wf_rptr <= wf_rptr + WPW'(1);
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wf_push) wf_mem[wf_wptr[WAW-1:0]] <= {~wb_sel_i, wb_dat_i};
  end

  assign sdr_wr_data = wf_head[DW-1:0];
  assign sdr_wr_en_n = wf_empty ? {SW{1'b1}} : wf_head[WFW-1:DW];

  // Read FIFO; beats arriving while full are dropped and flagged
  logic [DW-1:0]  rf_mem [RFD];
  logic [RPW-1:0] rf_wptr, rf_rptr;

  assign rf_empty = (rf_wptr == rf_rptr);
  assign rf_full  = (rf_wptr[RAW] != rf_rptr[RAW]) &&
                    (rf_wptr[RAW-1:0] == rf_rptr[RAW-1:0]);
  assign rf_push  = sdr_rd_valid && !rf_full;
  assign wb_dat_o = rf_mem[rf_rptr[RAW-1:0]];

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      rf_wptr  <= '0;
      rf_rptr  <= '0;
      rd_ovf_o <= 1'b0;
    end else begin
      if (rf_push) rf_wptr <= rf_wptr + RPW'(1);
      if (rf_pop)  rf_rptr <= rf_rptr + RPW'(1);
      if (sdr_rd_valid && rf_full) rd_ovf_o <= 1'b1;
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (rf_push) rf_mem[rf_wptr[RAW-1:0]] <= sdr_rd_data;
  end

  // Received-beat counter; saturates so stray beats can never wrap it
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      rcv_cnt <= '0;
    end else if (state == IDLE && state_n == RD_ISSUE) begin
      rcv_cnt <= '0;
    end else if (sdr_rd_valid && rcv_cnt != {BL{1'b1}}) begin
      rcv_cnt <= rcv_cnt + BL'(1);
    end
  end

  assign wr_req    = wb_stb_i && wb_cyc_i && wb_we_i;
  assign rd_req    = wb_stb_i && wb_cyc_i && !wb_we_i;
  assign incr      = (wb_cti_i == 3'b010);
  assign beat_inc  = beat_cnt + BL'(1);
  assign next_addr = start_addr + APP_AW'(beat_cnt);

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state      <= IDLE;
      start_addr <= '0;
      beat_cnt   <= '0;
      len_q      <= '0;
      ack_cnt    <= '0;
    end else begin
      state      <= state_n;
      start_addr <= start_addr_n;
      beat_cnt   <= beat_cnt_n;
      len_q      <= len_n;
      ack_cnt    <= ack_cnt_n;
    end
  end

  always_comb begin
    state_n      = state;
    start_addr_n = start_addr;
    beat_cnt_n   = beat_cnt;
    len_n        = len_q;
    ack_cnt_n    = ack_cnt;
    wb_ack_o     = 1'b0;
    wf_push      = 1'b0;
    rf_pop       = 1'b0;
    case (state)
      IDLE, WR_COLLECT: begin
        if (state == WR_COLLECT &&
            (!wb_cyc_i || (wb_stb_i && (!wb_we_i || wb_addr_i != next_addr)))) begin
          state_n = WR_ISSUE;
        end else if (wr_req) begin
          if (!wf_full) begin
            wb_ack_o   = 1'b1;
            wf_push    = 1'b1;
            beat_cnt_n = beat_inc;
            if (beat_cnt == '0) start_addr_n = wb_addr_i;
            state_n = (!incr || beat_inc == BL'(MAX_BURST)) ? WR_ISSUE : WR_COLLECT;
          end
        end else if (rd_req && state == IDLE) begin
          start_addr_n = wb_addr_i;
          len_n        = incr ? BL'(MAX_BURST) - BL'(wb_addr_i[MBW-1:0]) : BL'(1);
          ack_cnt_n    = '0;
          state_n      = RD_ISSUE;
        end
      end
      WR_ISSUE: begin
        if (sdr_req_ack) begin
          beat_cnt_n = '0;
          state_n    = IDLE;
        end
      end
      // Held off until all pending write data has gone to the controller
      RD_ISSUE: begin
        if (wf_empty && sdr_req_ack) state_n = RD_DATA;
      end
      RD_DATA: begin
        if (rd_req && !rf_empty) begin
          wb_ack_o  = 1'b1;
          rf_pop    = 1'b1;
          ack_cnt_n = ack_cnt + BL'(1);
          if (ack_cnt_n == len_q) state_n = IDLE;
          else if (!incr)         state_n = RD_DRAIN;
        end else if (!wb_cyc_i) begin
          state_n = RD_DRAIN;
        end
      end
      RD_DRAIN: begin
        rf_pop = !rf_empty;
        if (rcv_cnt >= len_q && rf_empty) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign sdr_req      = (state == WR_ISSUE) || (state == RD_ISSUE && wf_empty);
  assign sdr_req_addr = start_addr;
  assign sdr_req_wr_n = (state != WR_ISSUE);

  always_comb begin
    sdr_req_len = '0;
    if (state == WR_ISSUE)      sdr_req_len = beat_cnt;
    else if (state == RD_ISSUE) sdr_req_len = len_q;
  end

endmodule

// File: tb/tb_wb2sdrc_burst.sv
// Directed bench for wb2sdrc_burst: Wishbone master and SDRAM-controller stand-in
// driven from one sequence, with commands and data checked through scoreboard queues.
module tb_wb2sdrc_burst;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 26;
  localparam int unsigned BL = 9;
  localparam int unsigned SW = DW / 8;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [BL-1:0] len;
    logic          wr_n;
  } cmd_t;

  typedef struct packed {
    logic [SW-1:0] en_n;
    logic [DW-1:0] data;
  } wbeat_t;

  logic          wb_clk_i, wb_rst_i;
  logic          wb_stb_i, wb_cyc_i, wb_we_i;
  logic [2:0]    wb_cti_i;
  logic [AW-1:0] wb_addr_i;
  logic [DW-1:0] wb_dat_i, wb_dat_o;
  logic [SW-1:0] wb_sel_i;
  logic          wb_ack_o;
  logic          sdr_req, sdr_req_wr_n, sdr_req_ack;
  logic [AW-1:0] sdr_req_addr;
  logic [BL-1:0] sdr_req_len;
  logic          sdr_wr_next, sdr_rd_valid, rd_ovf_o;
  logic [DW-1:0] sdr_wr_data, sdr_rd_data;
  logic [SW-1:0] sdr_wr_en_n;

  cmd_t          cmd_q[$];
  wbeat_t        wdata_q[$];
  logic [DW-1:0] rdata_q[$];

  int errors = 0;
  int checks = 0;

  wb2sdrc_burst #(.DW(DW), .APP_AW(AW), .BL(BL), .MAX_BURST(8), .WFD(16), .RFD(16)) dut (
    .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i),
    .wb_stb_i(wb_stb_i), .wb_cyc_i(wb_cyc_i), .wb_we_i(wb_we_i), .wb_cti_i(wb_cti_i),
    .wb_addr_i(wb_addr_i), .wb_dat_i(wb_dat_i), .wb_sel_i(wb_sel_i),
    .wb_dat_o(wb_dat_o), .wb_ack_o(wb_ack_o),
    .sdr_req(sdr_req), .sdr_req_addr(sdr_req_addr), .sdr_req_len(sdr_req_len),
    .sdr_req_wr_n(sdr_req_wr_n), .sdr_req_ack(sdr_req_ack),
    .sdr_wr_next(sdr_wr_next), .sdr_wr_data(sdr_wr_data), .sdr_wr_en_n(sdr_wr_en_n),
    .sdr_rd_valid(sdr_rd_valid), .sdr_rd_data(sdr_rd_data), .rd_ovf_o(rd_ovf_o)
  );

  initial begin
    wb_clk_i = 1'b0;
    forever #5 wb_clk_i = ~wb_clk_i;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One Wishbone beat; holds the request until acked or the wait budget runs out
  task automatic wb_beat(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                         input logic [2:0] cti, output logic [DW-1:0] rd);
    int n = 0;
    wb_stb_i = 1'b1; wb_cyc_i = 1'b1; wb_we_i = we;
    wb_addr_i = a; wb_dat_i = d; wb_sel_i = '1; wb_cti_i = cti;
    #1;
    while (!wb_ack_o && n < 40) begin @(negedge wb_clk_i); #1; n++; end
    chk("wb_ack", 64'(wb_ack_o), 64'd1);
    rd = wb_dat_o;
    @(negedge wb_clk_i);
  endtask

  task automatic wb_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [2:0] cti);
    logic [DW-1:0] unused_rd;
    wdata_q.push_back('{en_n: '0, data: d});
    wb_beat(1'b1, a, d, cti, unused_rd);
  endtask

  task automatic wb_read_chk(input string tag, input logic [AW-1:0] a, input logic [2:0] cti);
    logic [DW-1:0] rd;
    logic [DW-1:0] exp;
    wb_beat(1'b0, a, '0, cti, rd);
    exp = (rdata_q.size() != 0) ? rdata_q.pop_front() : 'x;
    chk(tag, 64'(rd), 64'(exp));
  endtask

  task automatic wb_idle();
    wb_stb_i = 1'b0; wb_cyc_i = 1'b0; wb_we_i = 1'b0; wb_cti_i = 3'b000;
    #1;
  endtask

  // Read request from IDLE: one cycle of strobe, then the master waits with cyc held
  task automatic wb_read_start(input logic [AW-1:0] a, input logic [2:0] cti);
    wb_stb_i = 1'b1; wb_cyc_i = 1'b1; wb_we_i = 1'b0; wb_addr_i = a; wb_cti_i = cti;
    #1;
    chk("rd_req_noack", 64'(wb_ack_o), 64'd0);
    @(negedge wb_clk_i);
    wb_stb_i = 1'b0;
  endtask

  task automatic sdr_serve_cmd();
    cmd_t e;
    int n = 0;
    e = cmd_q.pop_front();
    #1;
    while (!sdr_req && n < 40) begin @(negedge wb_clk_i); #1; n++; end
    chk("req_seen", 64'(sdr_req), 64'd1);
    @(negedge wb_clk_i); #1;
    chk("req_held", 64'(sdr_req), 64'd1);
    chk("req_addr", 64'(sdr_req_addr), 64'(e.addr));
    chk("req_len",  64'(sdr_req_len),  64'(e.len));
    chk("req_wr_n", 64'(sdr_req_wr_n), 64'(e.wr_n));
    sdr_req_ack = 1'b1;
    @(negedge wb_clk_i);
    sdr_req_ack = 1'b0;
    #1;
    chk("req_drop", 64'(sdr_req), 64'd0);
  endtask

  task automatic sdr_pop_wdata(input int n);
    wbeat_t e;
    for (int i = 0; i < n; i++) begin
      e = wdata_q.pop_front();
      #1;
      chk("wr_data", 64'(sdr_wr_data), 64'(e.data));
      chk("wr_en_n", 64'(sdr_wr_en_n), 64'(e.en_n));
      sdr_wr_next = 1'b1;
      @(negedge wb_clk_i);
      sdr_wr_next = 1'b0;
    end
    #1;
    chk("wr_en_n_empty", 64'(sdr_wr_en_n), 64'hF);
  endtask

  task automatic sdr_push_rd(input logic [DW-1:0] d);
    rdata_q.push_back(d);
    sdr_rd_valid = 1'b1; sdr_rd_data = d;
    @(negedge wb_clk_i);
    sdr_rd_valid = 1'b0;
  endtask

  initial begin
    logic saw_req;
    wb_rst_i = 1'b1; wb_stb_i = 1'b0; wb_cyc_i = 1'b0; wb_we_i = 1'b0; wb_cti_i = 3'b000;
    wb_addr_i = '0; wb_dat_i = '0; wb_sel_i = '0;
    sdr_req_ack = 1'b0; sdr_wr_next = 1'b0; sdr_rd_valid = 1'b0; sdr_rd_data = '0;

    // Reset state
    repeat (3) @(negedge wb_clk_i);
    #1;
    chk("rst_req", 64'(sdr_req), 64'd0);
    chk("rst_ack", 64'(wb_ack_o), 64'd0);
    chk("rst_en_n", 64'(sdr_wr_en_n), 64'hF);
    chk("rst_len", 64'(sdr_req_len), 64'd0);
    chk("rst_wr_n", 64'(sdr_req_wr_n), 64'd1);
    chk("rst_ovf", 64'(rd_ovf_o), 64'd0);
    @(negedge wb_clk_i);
    wb_rst_i = 1'b0;
    @(negedge wb_clk_i);

    // Classic single write
    cmd_q.push_back('{addr: 26'h10, len: 9'd1, wr_n: 1'b0});
    wb_write(26'h10, 32'hA5A5_A5A5, 3'b000);
    wb_idle();
    chk("ack_low_idle", 64'(wb_ack_o), 64'd0);
    sdr_serve_cmd();
    sdr_pop_wdata(1);

    // Five-beat incrementing write ending with cti 111
    cmd_q.push_back('{addr: 26'h20, len: 9'd5, wr_n: 1'b0});
    for (int i = 0; i < 5; i++)
      wb_write(26'h20 + AW'(i), 32'h2000_0000 + DW'(i), (i == 4) ? 3'b111 : 3'b010);
    wb_idle();
    sdr_serve_cmd();
    sdr_pop_wdata(5);

    // Ten-beat write splits at MAX_BURST; master waits while the first command drains
    cmd_q.push_back('{addr: 26'h40, len: 9'd8, wr_n: 1'b0});
    for (int i = 0; i < 8; i++) wb_write(26'h40 + AW'(i), 32'h4000_0000 + DW'(i), 3'b010);
    wb_stb_i = 1'b0;
    sdr_serve_cmd();
    sdr_pop_wdata(8);
    cmd_q.push_back('{addr: 26'h48, len: 9'd2, wr_n: 1'b0});
    wb_write(26'h48, 32'h4000_0008, 3'b010);
    wb_write(26'h49, 32'h4000_0009, 3'b111);
    wb_idle();
    sdr_serve_cmd();
    sdr_pop_wdata(2);

    // Stalled strobe keeps the burst open; a non-contiguous address closes it unacked
    cmd_q.push_back('{addr: 26'h70, len: 9'd2, wr_n: 1'b0});
    wb_write(26'h70, 32'h7000_0000, 3'b010);
    wb_stb_i = 1'b0;
    repeat (3) @(negedge wb_clk_i);
    #1;
    chk("stall_no_req", 64'(sdr_req), 64'd0);
    wb_write(26'h71, 32'h7000_0001, 3'b010);
    wb_stb_i = 1'b1; wb_we_i = 1'b1; wb_addr_i = 26'h80; wb_cti_i = 3'b010;
    #1;
    chk("noncontig_noack", 64'(wb_ack_o), 64'd0);
    @(negedge wb_clk_i);
    wb_stb_i = 1'b0;
    sdr_serve_cmd();
    sdr_pop_wdata(2);
    wb_idle();

    // Incrementing read at 0x13 ended early by the master, then a classic read
    wb_read_start(26'h13, 3'b010);
    cmd_q.push_back('{addr: 26'h13, len: 9'd5, wr_n: 1'b1});
    sdr_serve_cmd();
    for (int i = 0; i < 5; i++) sdr_push_rd(32'h1300_0000 + DW'(i));
    wb_read_chk("rd_beat0", 26'h13, 3'b010);
    wb_read_chk("rd_beat1", 26'h14, 3'b111);
    wb_idle();
    repeat (3) void'(rdata_q.pop_front());
    repeat (6) @(negedge wb_clk_i);
    wb_read_start(26'h50, 3'b000);
    cmd_q.push_back('{addr: 26'h50, len: 9'd1, wr_n: 1'b1});
    sdr_serve_cmd();
    sdr_push_rd(32'hCAFE_F00D);
    wb_read_chk("rd_after_drain", 26'h50, 3'b000);
    wb_idle();

    // Read-after-write: read command waits until the write FIFO is empty
    cmd_q.push_back('{addr: 26'h30, len: 9'd1, wr_n: 1'b0});
    wb_write(26'h30, 32'h3030_3030, 3'b000);
    wb_idle();
    sdr_serve_cmd();
    wb_read_start(26'h30, 3'b000);
    saw_req = 1'b0;
    for (int i = 0; i < 4; i++) begin @(negedge wb_clk_i); #1; saw_req |= sdr_req; end
    chk("raw_read_held", 64'(saw_req), 64'd0);
    sdr_pop_wdata(1);
    cmd_q.push_back('{addr: 26'h30, len: 9'd1, wr_n: 1'b1});
    sdr_serve_cmd();
    sdr_push_rd(32'h3030_3030);
    wb_read_chk("raw_read_data", 26'h30, 3'b000);
    wb_idle();

    // Read FIFO overflow is sticky
    @(negedge wb_clk_i);
    sdr_rd_valid = 1'b1; sdr_rd_data = 32'hDEAD_0000;
    repeat (16) @(negedge wb_clk_i);
    sdr_rd_valid = 1'b0;
    #1;
    chk("ovf_not_yet", 64'(rd_ovf_o), 64'd0);
    sdr_rd_valid = 1'b1;
    @(negedge wb_clk_i);
    sdr_rd_valid = 1'b0;
    #1;
    chk("ovf_set", 64'(rd_ovf_o), 64'd1);
    repeat (3) @(negedge wb_clk_i);
    #1;
    chk("ovf_sticky", 64'(rd_ovf_o), 64'd1);

    // Reset in WR_COLLECT abandons the burst
    wb_write(26'h60, 32'h6000_0000, 3'b010);
    wb_write(26'h61, 32'h6000_0001, 3'b010);
    wb_stb_i = 1'b0; wb_rst_i = 1'b1;
    @(negedge wb_clk_i);
    wb_rst_i = 1'b0;
    wb_idle();
    wdata_q.delete();
    chk("rst2_ovf", 64'(rd_ovf_o), 64'd0);
    chk("rst2_en_n", 64'(sdr_wr_en_n), 64'hF);
    chk("rst2_len", 64'(sdr_req_len), 64'd0);
    saw_req = sdr_req;
    for (int i = 0; i < 8; i++) begin @(negedge wb_clk_i); #1; saw_req |= sdr_req; end
    chk("rst2_no_req", 64'(saw_req), 64'd0);

    // Bridge is usable again after the abandoned burst
    cmd_q.push_back('{addr: 26'h90, len: 9'd1, wr_n: 1'b0});
    wb_write(26'h90, 32'h9090_9090, 3'b000);
    wb_idle();
    sdr_serve_cmd();
    sdr_pop_wdata(1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
